// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, duty code type and the duty-to-threshold mapping
// used by pwm_multi_ch and pwm_channel.
package pwm_pkg;

    localparam int unsigned CBITS_DEF = 18;
    localparam int unsigned DBITS_DEF = 4;
    localparam int unsigned NCH_DEF   = 4;

    typedef logic [DBITS_DEF-1:0] duty_t;

    // Compare threshold for duty code d: {1'b0, d, 1'b1, zeros} = (2d+1) * 2^(cbits-dbits-2).
    // Centring each code in its bin keeps duty 0 strictly above zero high time.
    function automatic int unsigned thr(input int unsigned cbits,
                                        input int unsigned dbits,
                                        input int unsigned d);
        return ((2 * d + 1) << (cbits - dbits - 2));
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM duty channel.
// Holds the pending/active duty pair; pend takes writes at any time, act
// reloads from pend only on the boundary cycle so a period never changes
// threshold mid-way. Output is registered (one cycle behind pc).
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   en        enable; output forced low while en=0
//   wr, val   duty write strobe (already decoded for this channel) and code
//   pc        counter value this channel compares against
//   bound     boundary cycle for this channel (en && pc == all-ones)
//   pulse     registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CBITS = CBITS_DEF,
    parameter int unsigned DBITS = DBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DBITS-1:0] val,
    input  logic [CBITS-1:0] pc,
    input  logic             bound,
    output logic             pulse
);

    logic [DBITS-1:0] pend;
    logic [DBITS-1:0] act;
    logic [CBITS-1:0] thr_act;

    assign thr_act = CBITS'(thr(CBITS, DBITS, 32'(act)));

    // A write landing on the boundary bypasses pend so it applies next period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '0;
            act   <= '0;
            pulse <= 1'b0;
        end else begin
            if (wr) begin
                pend <= val;
            end
            if (bound) begin
                act <= wr ? val : pend;
            end
            pulse <= en && (pc < thr_act);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator with a shared free-running
// period counter, NCH shadowed duty channels and lower/upper bound
// reference pulses for downstream bracketing checks.
// Optional build macro PWM_PHASE_STAGGER_EN: channel i compares against
// cnt + i*2^CBITS/NCH and shadow-updates at its own wrap; reference pulses
// and period_start stay on the unshifted counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            counter/PWM enable (counter holds while low)
//   duty_wr       duty write strobe
//   duty_ch       channel index for the write (out-of-range ignored)
//   duty_val      duty code to write
//   pulse         PWM outputs, bit i = channel i
//   lb_pulse      reference pulse for duty code 0
//   ub_pulse      reference pulse for duty code 2^DBITS-1
//   period_start  one-cycle strobe in the first cycle of each period
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CBITS = CBITS_DEF,
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned DBITS = DBITS_DEF,
    localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             duty_wr,
    input  logic [CHW-1:0]   duty_ch,
    input  logic [DBITS-1:0] duty_val,
    output logic [NCH-1:0]   pulse,
    output logic             lb_pulse,
    output logic             ub_pulse,
    output logic             period_start
);

    if (CBITS < DBITS + 2) begin : g_bad_cfg
        $error("pwm_multi_ch: CBITS must be >= DBITS+2");
    end

    localparam logic [CBITS-1:0] THR_LB = CBITS'(thr(CBITS, DBITS, 0));
    localparam logic [CBITS-1:0] THR_UB = CBITS'(thr(CBITS, DBITS, (1 << DBITS) - 1));

    logic [CBITS-1:0] cnt;
    logic             boundary;

    assign boundary = en && (&cnt);

    // Shared period counter; frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CBITS'(1);
        end
    end

    // Reference pulses and period strobe, aligned with the channel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_pulse     <= 1'b0;
            ub_pulse     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            lb_pulse     <= en && (cnt < THR_LB);
            ub_pulse     <= en && (cnt < THR_UB);
            period_start <= boundary;
        end
    end

    // Per-channel write decode and compare counter.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             wr;
        logic [CBITS-1:0] pc;
        logic             bound;

        assign wr = duty_wr && (duty_ch == CHW'(i));

`ifdef PWM_PHASE_STAGGER_EN
        localparam int unsigned OFF = (i * (1 << CBITS)) / NCH;
        assign pc    = cnt + CBITS'(OFF);
        assign bound = en && (&pc);
`else
        assign pc    = cnt;
        assign bound = boundary;
`endif

        pwm_channel #(
            .CBITS (CBITS),
            .DBITS (DBITS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .wr    (wr),
            .val   (duty_val),
            .pc    (pc),
            .bound (bound),
            .pulse (pulse[i])
        );
    end

`ifndef SYNTHESIS
`ifdef PWM_PHASE_STAGGER_EN
    localparam int unsigned NINV = 1;
`else
    localparam int unsigned NINV = NCH;
`endif
    // Every edge-aligned channel lies between the two reference pulses.
    for (genvar k = 0; k < NINV; k++) begin : g_inv
        a_bound : assert property (@(posedge clk) disable iff (rst)
            (!lb_pulse || pulse[k]) && (ub_pulse || !pulse[k]));
    end
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed self-checking bench for pwm_multi_ch with
// CBITS=8, DBITS=2 (thresholds 16/48/80/112, period 256).
// u_dut has NCH=4. Its 2-bit duty_ch cannot carry an out-of-range index,
// so u_dut1 (NCH=1, 1-bit duty_ch) exercises the ignored-write case.
module tb_pwm_multi_ch;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       duty_wr;
    logic [1:0] duty_ch;
    logic [1:0] duty_val;
    logic [3:0] pulse;
    logic       lb_pulse, ub_pulse, period_start;

    logic       duty_wr1;
    logic       duty_ch1;
    logic [1:0] duty_val1;
    logic       pulse1, lb1, ub1, ps1;

    always #5 clk = ~clk;

    pwm_multi_ch #(.CBITS(8), .NCH(4), .DBITS(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty_wr      (duty_wr),
        .duty_ch      (duty_ch),
        .duty_val     (duty_val),
        .pulse        (pulse),
        .lb_pulse     (lb_pulse),
        .ub_pulse     (ub_pulse),
        .period_start (period_start)
    );

    pwm_multi_ch #(.CBITS(8), .NCH(1), .DBITS(2)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty_wr      (duty_wr1),
        .duty_ch      (duty_ch1),
        .duty_val     (duty_val1),
        .pulse        (pulse1),
        .lb_pulse     (lb1),
        .ub_pulse     (ub1),
        .period_start (ps1)
    );

    // Reference period counter; outputs sampled at a negedge reflect mcnt-1.
    logic [7:0] mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= 8'd0;
        else if (en) mcnt <= mcnt + 8'd1;
    end

    int tests = 0;
    int errors = 0;
    int hi[4];
    int hlb, hub, hps, hinv, hp1;

    // Advance negedges until mcnt == v (bounded).
    task automatic wait_cnt(input logic [7:0] v);
        int n;
        n = 0;
        while (mcnt !== v) begin
            @(negedge clk);
            n++;
            if (n > 600) begin
                tests++;
                errors++;
                $display("FAIL wait_cnt: mcnt=%0d required=%0d (timeout)", mcnt, v);
                return;
            end
        end
    endtask

    task automatic clear_acc();
        for (int i = 0; i < 4; i++) hi[i] = 0;
        hlb = 0; hub = 0; hps = 0; hinv = 0; hp1 = 0;
    endtask

    // Accumulate one negedge sample of all outputs plus bound-invariant hits.
    task automatic sample();
        for (int i = 0; i < 4; i++) begin
            if (pulse[i]) hi[i]++;
            if ((lb_pulse && !pulse[i]) || (!ub_pulse && pulse[i])) hinv++;
        end
        if ((lb1 && !pulse1) || (!ub1 && pulse1)) hinv++;
        if (lb_pulse) hlb++;
        if (ub_pulse) hub++;
        if (period_start) hps++;
        if (pulse1) hp1++;
    endtask

    // One full period of samples, covering cnt = 0..255.
    task automatic measure_window();
        wait_cnt(8'd1);
        clear_acc();
        for (int j = 0; j < 256; j++) begin
            if (j > 0) @(negedge clk);
            sample();
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [1:0] val);
        duty_ch = ch; duty_val = val; duty_wr = 1'b1;
        @(negedge clk);
        duty_wr = 1'b0;
    endtask

    task automatic do_write1(input logic ch, input logic [1:0] val);
        duty_ch1 = ch; duty_val1 = val; duty_wr1 = 1'b1;
        @(negedge clk);
        duty_wr1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        duty_wr = 1'b0; duty_ch = 2'd0; duty_val = 2'd0;
        duty_wr1 = 1'b0; duty_ch1 = 1'b0; duty_val1 = 2'd0;
        repeat (3) @(negedge clk);
        tests++; if (pulse !== 4'b0000) begin errors++; $display("FAIL reset_pulse: got %b want 0000", pulse); end
        tests++; if (lb_pulse !== 1'b0) begin errors++; $display("FAIL reset_lb: got %b want 0", lb_pulse); end
        tests++; if (ub_pulse !== 1'b0) begin errors++; $display("FAIL reset_ub: got %b want 0", ub_pulse); end
        tests++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b want 0", period_start); end
        tests++; if ({pulse1, lb1, ub1, ps1} !== 4'b0000) begin errors++; $display("FAIL reset_dut1: got %b want 0000", {pulse1, lb1, ub1, ps1}); end
    endtask

    // Check a measured window against expected high times.
    task automatic test_window(input string name, input int e0, input int e1,
                               input int e2, input int e3, input int ep1);
        int exp[4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        measure_window();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (hi[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s pulse[%0d]: high %0d want %0d", name, i, hi[i], exp[i]);
            end
        end
        tests++; if (hlb !== 16) begin errors++; $display("FAIL %s lb: high %0d want 16", name, hlb); end
        tests++; if (hub !== 112) begin errors++; $display("FAIL %s ub: high %0d want 112", name, hub); end
        tests++; if (hps !== 1) begin errors++; $display("FAIL %s period_start: count %0d want 1", name, hps); end
        tests++; if (hp1 !== ep1) begin errors++; $display("FAIL %s dut1_pulse: high %0d want %0d", name, hp1, ep1); end
        tests++; if (hinv !== 0) begin errors++; $display("FAIL %s invariant: %0d violations want 0", name, hinv); end
    endtask

    task automatic test_default();
        rst = 1'b0; en = 1'b1;
        test_window("default", 16, 16, 16, 16, 16);
        test_window("default2", 16, 16, 16, 16, 16);
    endtask

    task automatic test_write_midperiod();
        int p2;
        wait_cnt(8'd40);
        do_write(2'd2, 2'd3);
        p2 = 0;
        for (int j = 0; j < 300; j++) begin
            if (pulse[2]) p2++;
            if (mcnt == 8'd0) break;
            @(negedge clk);
        end
        tests++; if (p2 !== 0) begin errors++; $display("FAIL mid_write_same_period: pulse[2] high %0d want 0", p2); end
        test_window("mid_write_next", 16, 16, 112, 16, 16);
    endtask

    task automatic test_boundary_write();
        wait_cnt(8'd255);
        do_write(2'd1, 2'd2);
        test_window("boundary_write", 16, 80, 112, 16, 16);
    endtask

    task automatic test_back_to_back();
        wait_cnt(8'd60);
        do_write(2'd3, 2'd1);
        do_write(2'd3, 2'd2);
        test_window("back_to_back", 16, 80, 112, 80, 16);
    endtask

    task automatic test_bad_channel();
        wait_cnt(8'd50);
        do_write1(1'b1, 2'd3);
        wait_cnt(8'd255);
        do_write1(1'b1, 2'd3);
        test_window("bad_channel", 16, 80, 112, 80, 16);
    endtask

    task automatic test_enable_pause();
        int nz;
        wait_cnt(8'd30);
        en = 1'b0;
        nz = 0;
        repeat (50) begin
            @(negedge clk);
            if ((pulse !== 4'b0) || lb_pulse || ub_pulse || period_start || pulse1) nz++;
        end
        tests++; if (nz !== 0) begin errors++; $display("FAIL pause_outputs: %0d nonzero samples want 0", nz); end
        tests++; if (mcnt !== 8'd30) begin errors++; $display("FAIL pause_ref_cnt: %0d want 30", mcnt); end
        en = 1'b1;
        clear_acc();
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            sample();
            if (mcnt == 8'd0) break;
        end
        tests++; if (hi[0] !== 0) begin errors++; $display("FAIL resume pulse[0]: high %0d want 0", hi[0]); end
        tests++; if (hi[1] !== 50) begin errors++; $display("FAIL resume pulse[1]: high %0d want 50", hi[1]); end
        tests++; if (hi[2] !== 82) begin errors++; $display("FAIL resume pulse[2]: high %0d want 82", hi[2]); end
        tests++; if (hi[3] !== 50) begin errors++; $display("FAIL resume pulse[3]: high %0d want 50", hi[3]); end
        tests++; if (hlb !== 0) begin errors++; $display("FAIL resume lb: high %0d want 0", hlb); end
        tests++; if (hub !== 82) begin errors++; $display("FAIL resume ub: high %0d want 82", hub); end
        tests++; if (hps !== 1) begin errors++; $display("FAIL resume period_start: count %0d want 1", hps); end
        tests++; if (hinv !== 0) begin errors++; $display("FAIL resume invariant: %0d violations want 0", hinv); end
        test_window("after_resume", 16, 80, 112, 80, 16);
    endtask

    task automatic test_reset_mid();
        wait_cnt(8'd2);
        do_write(2'd0, 2'd3);
        do_write(2'd1, 2'd3);
        do_write(2'd2, 2'd3);
        do_write(2'd3, 2'd3);
        test_window("all_max", 112, 112, 112, 112, 16);
        wait_cnt(8'd100);
        rst = 1'b1;
        #1;
        tests++; if (pulse !== 4'b0000) begin errors++; $display("FAIL midreset_pulse: got %b want 0000", pulse); end
        tests++; if ({lb_pulse, ub_pulse, period_start} !== 3'b000) begin errors++; $display("FAIL midreset_refs: got %b want 000", {lb_pulse, ub_pulse, period_start}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_window("after_reset", 16, 16, 16, 16, 16);
    endtask

    initial begin
        test_reset();
        test_default();
        test_write_midperiod();
        test_boundary_write();
        test_back_to_back();
        test_bad_channel();
        test_enable_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
